scancode_history: RTL and testbench

Parametrised history buffer for the PS/2-to-VGA path. It captures bytes from the PS/2 receiver on a strobe and keeps the last DEPTH of them, newest first, for the character renderer. It adds several behaviours to the fixed 6×8 shift chain:
- strobe synchronisation into the pixel/system clock
- occupancy tracking
- backspace (pop newest) and clear
- optional break-code filtering, so key releases do not enter the history

---
 rtl/scancode_history_if.sv | 27 ++
 rtl/scancode_history.sv | 144 ++++++++++++++
 tb/tb_scancode_history.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/scancode_history_if.sv
// Bundles the byte-capture inputs and the history outputs of scancode_history.
// master: the side that sends bytes and commands and reads the history back.
// slave:  the history buffer itself.
interface scancode_history_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 6
);
    logic [WIDTH-1:0]             data;    // byte from the PS/2 receiver
    logic                         shren;   // byte strobe, asynchronous to clk
    logic                         pop;     // remove newest entry (backspace)
    logic                         clr;     // empty the buffer
    logic [DEPTH*WIDTH-1:0]       dout;    // entries packed, entry 0 (newest) in the low bits
    logic [$clog2(DEPTH+1)-1:0]   count;   // number of valid entries
    logic                         empty;   // count == 0
    logic                         full;    // count == DEPTH
    logic                         pushed;  // one-cycle pulse per stored entry

    modport master (
        output data, shren, pop, clr,
        input  dout, count, empty, full, pushed
    );

    modport slave (
        input  data, shren, pop, clr,
        output dout, count, empty, full, pushed
    );
endinterface

// File: rtl/scancode_history.sv
// Keeps the last DEPTH bytes from the PS/2 receiver, newest first, with backspace/clear and break filtering.
// Latency: strobe rising before edge k is stored on edge k+2; pop/clr act on the edge they are sampled high.
// No backpressure: pushes when full drop the oldest entry, pops when empty are ignored.
//
// Ports: clk, rst (async, active low); bus (slave modport) carries data/shren/pop/clr in and
// dout/count/empty/full/pushed out. empty/full are decoded from the count register, the rest are flops.
module scancode_history #(
    parameter int               WIDTH        = 8,
    parameter int               DEPTH        = 6,
    parameter bit               FILTER_BREAK = 1'b1,
    parameter logic [WIDTH-1:0] BREAK_CODE   = 8'hF0
) (
    input  logic                clk,
    input  logic                rst,
    scancode_history_if.slave   bus
);

    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SKIP = 1'b1
    } flt_state_e;

    // strobe synchroniser and edge detector
    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       s3_q, s3_d;
    // warm_q marks the first two edges after reset, when s2 still holds its reset
    // value instead of a real sample of shren. armed_q is set only once a genuine
    // low level of shren has been seen, so a strobe already high at reset release
    // cannot masquerade as a fresh rising edge.
    logic [1:0] warm_q, warm_d;
    logic       armed_q, armed_d;

    logic [WIDTH-1:0] ent_q [DEPTH];
    logic [WIDTH-1:0] ent_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             pushed_q, pushed_d;
    flt_state_e       state_q, state_d;

    logic strobe;
    logic accept;

    assign strobe = s2_q & ~s3_q & armed_q;

    always_comb begin
        s1_d     = bus.shren;
        s2_d     = s1_q;
        s3_d     = s2_q;
        warm_d   = {warm_q[0], 1'b1};
        armed_d  = armed_q | (warm_q[1] & ~s2_q);
        ent_d    = ent_q;
        count_d  = count_q;
        pushed_d = 1'b0;
        state_d  = state_q;
        accept   = 1'b0;

        // Break filter: the prefix and the byte after it never reach the history.
        if (strobe) begin
            if (FILTER_BREAK) begin
                case (state_q)
                    IDLE: begin
                        if (bus.data == BREAK_CODE) begin
                            state_d = SKIP;
                        end else begin
                            accept = 1'b1;
                        end
                    end
                    SKIP: state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end else begin
                accept = 1'b1;
            end
        end

        if (bus.clr) begin
            // Clear wins over everything, including a strobe in the same cycle.
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i] = '0;
            end
            count_d = '0;
            state_d = IDLE;
        end else if (accept && bus.pop && (count_q != '0)) begin
            // Backspace and new key together: overwrite the newest entry.
            ent_d[0] = bus.data;
            pushed_d = 1'b1;
        end else if (accept) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                ent_d[i] = ent_q[i-1];
            end
            ent_d[0] = bus.data;
            if (count_q != DEPTH_C) begin
                count_d = count_q + CW'(1);
            end
            pushed_d = 1'b1;
        end else if (bus.pop && (count_q != '0)) begin
            // Zero-fill from the top so entries beyond count always read 0.
            for (int i = 0; i < DEPTH - 1; i++) begin
                ent_d[i] = ent_q[i+1];
            end
            ent_d[DEPTH-1] = '0;
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            warm_q   <= 2'b00;
            armed_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            count_q  <= '0;
            pushed_q <= 1'b0;
            state_q  <= IDLE;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            warm_q   <= warm_d;
            armed_q  <= armed_d;
            ent_q    <= ent_d;
            count_q  <= count_d;
            pushed_q <= pushed_d;
            state_q  <= state_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_dout
        assign bus.dout[g*WIDTH +: WIDTH] = ent_q[g];
    end

    assign bus.count  = count_q;
    assign bus.pushed = pushed_q;
    assign bus.empty  = (count_q == '0);
    assign bus.full   = (count_q == DEPTH_C);

endmodule

// File: tb/tb_scancode_history.sv
// Drives two histories (break filter on / off) with the same byte sequence and checks both
// every cycle against a list-of-bytes model, plus literal expectations after each scenario.
module tb_scancode_history;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       shren;
    logic       pop;
    logic       clr;

    scancode_history_if #(.WIDTH(8), .DEPTH(6)) b0 ();
    scancode_history_if #(.WIDTH(8), .DEPTH(6)) b1 ();

    assign b0.data  = data;
    assign b0.shren = shren;
    assign b0.pop   = pop;
    assign b0.clr   = clr;
    assign b1.data  = data;
    assign b1.shren = shren;
    assign b1.pop   = pop;
    assign b1.clr   = clr;

    scancode_history #(.WIDTH(8), .DEPTH(6), .FILTER_BREAK(1'b1), .BREAK_CODE(8'hF0)) u_flt (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    scancode_history #(.WIDTH(8), .DEPTH(6), .FILTER_BREAK(1'b0), .BREAK_CODE(8'hF0)) u_raw (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;
    int pulses [2];

    // ---------------- model: history as a newest-first list ----------------
    logic [7:0] m_ent [2][6];
    int         m_cnt [2];
    bit         m_skip [2];
    bit         m_pushed [2];
    int         nedge;          // edges since reset release
    bit         h1, h2, h3;     // shren samples at edges n-1, n-2, n-3

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_cnt[m]    = 0;
            m_skip[m]   = 0;
            m_pushed[m] = 0;
        end
        nedge = 0;
        h1 = 0; h2 = 0; h3 = 0;
    endtask

    // A rising shren seen at two real samples is stored two edges after it is first sampled.
    task automatic model_step();
        bit ev;
        bit acc;
        if (!rst) return;
        ev = (nedge + 1 >= 4) && h2 && !h3;
        h3 = h2; h2 = h1; h1 = shren;
        nedge++;
        for (int m = 0; m < 2; m++) begin
            m_pushed[m] = 0;
            acc = 0;
            if (clr) begin
                m_cnt[m]  = 0;
                m_skip[m] = 0;
            end else begin
                if (ev) begin
                    if (m == 0 && m_skip[m])            m_skip[m] = 0;
                    else if (m == 0 && data == 8'hF0)   m_skip[m] = 1;
                    else                                acc = 1;
                end
                if (acc && pop && m_cnt[m] > 0) begin
                    m_ent[m][0] = data;
                    m_pushed[m] = 1;
                end else if (acc) begin
                    for (int i = 5; i > 0; i--) m_ent[m][i] = m_ent[m][i-1];
                    m_ent[m][0] = data;
                    if (m_cnt[m] < 6) m_cnt[m]++;
                    m_pushed[m] = 1;
                end else if (pop && m_cnt[m] > 0) begin
                    for (int i = 0; i < 5; i++) m_ent[m][i] = m_ent[m][i+1];
                    m_cnt[m]--;
                end
            end
        end
    endtask

    function automatic logic [47:0] exp_dout(int m);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < m_cnt[m]; i++) r[i*8 +: 8] = m_ent[m][i];
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic act_of(input int m, output logic [47:0] d, output logic [47:0] c,
                          output logic e, output logic f, output logic p);
        if (m == 0) begin
            d = b0.dout; c = 48'(b0.count); e = b0.empty; f = b0.full; p = b0.pushed;
        end else begin
            d = b1.dout; c = 48'(b1.count); e = b1.empty; f = b1.full; p = b1.pushed;
        end
    endtask

    task automatic compare();
        logic [47:0] d, c;
        logic        e, f, p;
        if (!rst) return;
        for (int m = 0; m < 2; m++) begin
            act_of(m, d, c, e, f, p);
            pulses[m] += int'(p);
            chk($sformatf("cyc dout[%0d]", m),   d, exp_dout(m));
            chk($sformatf("cyc count[%0d]", m),  c, 48'(m_cnt[m]));
            chk($sformatf("cyc empty[%0d]", m),  48'(e), 48'(m_cnt[m] == 0));
            chk($sformatf("cyc full[%0d]", m),   48'(f), 48'(m_cnt[m] == 6));
            chk($sformatf("cyc pushed[%0d]", m), 48'(p), 48'(m_pushed[m]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic lit(input string name, input int m, input logic [47:0] ed, input int ec);
        logic [47:0] d, c;
        logic        e, f, p;
        act_of(m, d, c, e, f, p);
        chk($sformatf("%s dout[%0d]", name, m),  d, ed);
        chk($sformatf("%s count[%0d]", name, m), c, 48'(ec));
    endtask

    task automatic send(input logic [7:0] b, input logic p, input logic c);
        data = b; shren = 1'b1;
        tick(); tick();
        pop = p; clr = c;
        tick();
        pop = 1'b0; clr = 1'b0;
        tick();
        shren = 1'b0;
        repeat (4) tick();
    endtask

    task automatic pop_op();
        pop = 1'b1; tick(); pop = 1'b0; tick();
    endtask

    task automatic clr_op();
        clr = 1'b1; tick(); clr = 1'b0; tick();
    endtask

    task automatic reset_lits(input string name);
        logic [47:0] d, c;
        logic        e, f, p;
        for (int m = 0; m < 2; m++) begin
            act_of(m, d, c, e, f, p);
            chk($sformatf("%s dout[%0d]", name, m),   d, 48'h0);
            chk($sformatf("%s count[%0d]", name, m),  c, 48'h0);
            chk($sformatf("%s empty[%0d]", name, m),  48'(e), 48'h1);
            chk($sformatf("%s full[%0d]", name, m),   48'(f), 48'h0);
            chk($sformatf("%s pushed[%0d]", name, m), 48'(p), 48'h0);
        end
    endtask

    initial begin
        int p0, p1;
        tests = 0; fails = 0;
        pulses[0] = 0; pulses[1] = 0;
        rst = 1'b0; data = 8'h00; shren = 1'b0; pop = 1'b0; clr = 1'b0;
        model_reset();
        #7;
        reset_lits("reset");
        tick(); tick();
        rst = 1'b1;
        repeat (3) tick();

        // basic push, strobe held high for 20 cycles stores only once
        p0 = pulses[0]; p1 = pulses[1];
        data = 8'h1C; shren = 1'b1;
        tick(); tick(); tick();
        lit("first_push", 0, 48'h1C, 1);
        repeat (17) tick();
        shren = 1'b0;
        repeat (4) tick();
        lit("hold", 0, 48'h1C, 1);
        chk("hold pulses[0]", 48'(pulses[0] - p0), 48'd1);
        chk("hold pulses[1]", 48'(pulses[1] - p1), 48'd1);

        // fill and overflow
        clr_op();
        for (int b = 1; b <= 7; b++) send(8'(b), 1'b0, 1'b0);
        lit("fill", 0, 48'h020304050607, 6);
        lit("fill", 1, 48'h020304050607, 6);
        chk("fill full[0]", 48'(b0.full), 48'h1);

        // break filter
        clr_op();
        p0 = pulses[0]; p1 = pulses[1];
        send(8'h1C, 0, 0); send(8'hF0, 0, 0); send(8'h1C, 0, 0);
        send(8'hE0, 0, 0); send(8'h75, 0, 0);
        lit("filter", 0, 48'h0000001CE075, 3);
        lit("filter", 1, 48'h001CF01CE075, 5);
        chk("filter pulses[0]", 48'(pulses[0] - p0), 48'd3);
        chk("filter pulses[1]", 48'(pulses[1] - p1), 48'd5);

        // backspace and underflow
        clr_op();
        send(8'h21, 0, 0); send(8'h32, 0, 0); send(8'h1C, 0, 0);
        pop_op();
        lit("pop1", 0, 48'h2132, 2);
        pop_op(); pop_op(); pop_op();
        lit("pop4", 0, 48'h0, 0);
        lit("pop4", 1, 48'h0, 0);
        chk("pop4 empty[0]", 48'(b0.empty), 48'h1);

        // push coincident with pop replaces the newest entry
        send(8'h21, 0, 0); send(8'h32, 0, 0);
        send(8'h44, 1'b1, 1'b0);
        lit("replace", 0, 48'h2144, 2);
        lit("replace", 1, 48'h2144, 2);

        // clear coincident with a strobe while the filter is skipping
        send(8'hF0, 0, 0);
        lit("pre_clr", 0, 48'h2144, 2);
        send(8'h33, 1'b0, 1'b1);
        lit("clr_strobe", 0, 48'h0, 0);
        send(8'h1C, 0, 0);
        lit("after_clr", 0, 48'h1C, 1);
        lit("after_clr", 1, 48'h1C, 1);

        // pop coincident with a filtered strobe still pops
        send(8'hF0, 0, 0);
        send(8'h99, 1'b1, 1'b0);
        lit("drop_pop", 0, 48'h0, 0);
        lit("drop_pop", 1, 48'h1C99, 2);
        send(8'h1C, 0, 0);
        lit("idle_again", 0, 48'h1C, 1);

        // asynchronous reset between strobe rise and the push edge
        data = 8'hAA; shren = 1'b1;
        tick();
        #2 rst = 1'b0;
        model_reset();
        #1;
        reset_lits("async_rst");
        tick(); tick();
        rst = 1'b1;
        repeat (8) tick();
        lit("rst_held", 0, 48'h0, 0);
        lit("rst_held", 1, 48'h0, 0);
        shren = 1'b0;
        repeat (4) tick();
        send(8'h5A, 0, 0);
        lit("rst_after", 0, 48'h5A, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
